mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the core's single memory port between instruction fetch (requester A) and data load/store (requester B). A registered FSM grants one requester at a time with round-robin tie-break. It drives the datapath 2:1 select `sel` and steers address, write-enable and write data onto the port. A watchdog aborts accesses the memory never acknowledges.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max cycles waiting for mem_ready in SERVE; 0 disables watchdog

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
req_a  input  1  fetch request (read only), held until done_a
addr_a  input  AW  fetch address
req_b  input  1  data request, held until done_b
we_b  input  1  data write enable (1=store)
addr_b  input  AW  data address
wdata_b  input  DW  store data
done_a  output  1  one-cycle completion pulse to A
done_b  output  1  one-cycle completion pulse to B
err  output  1  valid with done_x; 1 = aborted by watchdog
rdata  output  DW  read data; valid while done_a or done_b
sel  output  1  owner select: 0=A, 1=B (same polarity as datapath mux control: 1 picks B)
mem_req  output  1  memory access strobe, level
mem_we  output  1  write enable to memory (we_b when sel=1, else 0)
mem_addr  output  AW  sel ? addr_b : addr_a (combinational from registered sel)
mem_wdata  output  DW  wdata_b
mem_ready  input  1  memory acknowledge, sampled only while mem_req=1
mem_rdata  input  DW  memory read data, valid with mem_ready

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, last=1 (A wins first tie), mem_req=0, done_a=done_b=0, err=0, rdata=0, wd_cnt=0. Reset mid-access drops mem_req at once; the pending request is lost and the requester must re-issue.
- FSM states:
  - IDLE: eff_a = req_a & ~done_a; eff_b = req_b & ~done_b. Masking prevents regrant of a requester that sees its done this cycle.
  - Grant rules: if only one eff_x is high, grant it. If both are high, grant A when last=1, else B. On grant at the edge: sel<=owner, last<=owner, mem_req<=1, wd_cnt<=0, state<=SERVE. No eff_x high: stay in IDLE; sel holds.
  - SERVE: mem_req=1 and sel stable. mem_ready=1 at edge: rdata<=mem_rdata, done_owner<=1, err<=0, mem_req<=0, state<=IDLE.
  - Watchdog (TIMEOUT>0): if mem_ready=0 and wd_cnt==TIMEOUT-1 at edge, then done_owner<=1, err<=1, rdata<=0, mem_req<=0, state<=IDLE. Otherwise wd_cnt<=wd_cnt+1; width is clog2(TIMEOUT+1), with no wrap in normal operation.
- done_x, err, rdata are registered; done_x and err are high exactly one cycle.
- Latency: request seen at edge N → mem_req high after edge N. mem_ready at edge M → done after edge M. Minimum request-to-done latency is 2 cycles. Back-to-back grant: next grant at the edge after done, so min 1 idle cycle between accesses.
- Round-robin under continuous contention alternates A,B,A,B. A lone requester is served repeatedly without waiting.
- Requester inputs are stable while req_x high. Behaviour when req is dropped before done is undefined; the access completes and done is still pulsed.
- mem_ready while mem_req=0 is ignored.

Test Plan:
1. Reset, req_a=1, addr_a=0x100, mem_ready 1 cycle after mem_req with mem_rdata=0xDEADBEEF → sel=0, mem_addr=0x100, mem_we=0, done_a one cycle with rdata=0xDEADBEEF, err=0.
2. req_a and req_b both rise in the same cycle, held, and re-requested after each done → grant order A,B,A,B. mem_addr alternates addr_a/addr_b; sel toggles 0,1,0,1.
3. req_b=1, we_b=1, addr_b=0x20, wdata_b=0x55AA → mem_we=1, mem_wdata=0x55AA, mem_addr=0x20; done_b pulses and done_a stays 0.
4. TIMEOUT=16, mem_ready held 0 → mem_req high exactly 16 cycles; done_a and err pulse together; FSM returns to IDLE and serves a pending req_b next.
5. Assert rst_n=0 while mem_req=1 mid-access → mem_req, sel, done_x fall to 0 asynchronously before the next edge. After release, the first tie grants A.
6. Requester keeps req_a high one cycle past done_a → no duplicate grant in that cycle (masking); a second access is granted only if req_a is still high the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch (A)
// and data load/store (B). Round-robin on ties, registered completion pulses,
// and a watchdog that aborts accesses the memory never acknowledges.
module mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_a,
   input  logic [AW-1:0] addr_a,
   input  logic          req_b,
   input  logic          we_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_b,
   output logic          done_a,
   output logic          done_b,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic          sel,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata
);

   // Watchdog counter is at least one bit wide so TIMEOUT=0 still elaborates.
   localparam int unsigned WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WdW-1:0] WdLast = WdW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [0:0] {StIdle, StServe} state_e;

   state_e         state_q, state_d;
   logic           sel_q, sel_d;
   logic           last_q, last_d;
   logic           mem_req_q, mem_req_d;
   logic           done_a_q, done_a_d;
   logic           done_b_q, done_b_d;
   logic           err_q, err_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic [WdW-1:0] wd_cnt_q, wd_cnt_d;

   logic eff_a, eff_b, grant_b;

   // Requesters seeing their done this cycle are masked so they are not regranted.
   assign eff_a = req_a & ~done_a_q;
   assign eff_b = req_b & ~done_b_q;

   // State register: reset drops mem_req immediately and makes A win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sel_q     <= 1'b0;
         last_q    <= 1'b1;
         mem_req_q <= 1'b0;
         done_a_q  <= 1'b0;
         done_b_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         wd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         mem_req_q <= mem_req_d;
         done_a_q  <= done_a_d;
         done_b_q  <= done_b_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         wd_cnt_q  <= wd_cnt_d;
      end
   end

   // Next-state: grant in IDLE, complete or time out in SERVE.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      mem_req_d = mem_req_q;
      done_a_d  = 1'b0;
      done_b_d  = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      wd_cnt_d  = wd_cnt_q;
      grant_b   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (eff_a || eff_b) begin
               // On a tie, the requester that did not own the port last goes first.
               grant_b   = eff_b & (~eff_a | ~last_q);
               sel_d     = grant_b;
               last_d    = grant_b;
               mem_req_d = 1'b1;
               wd_cnt_d  = '0;
               state_d   = StServe;
            end
         end
         StServe: begin
            if (mem_ready) begin
               rdata_d   = mem_rdata;
               done_a_d  = ~sel_q;
               done_b_d  = sel_q;
               mem_req_d = 1'b0;
               state_d   = StIdle;
            end else if (TIMEOUT != 0) begin
               if (wd_cnt_q == WdLast) begin
                  rdata_d   = '0;
                  err_d     = 1'b1;
                  done_a_d  = ~sel_q;
                  done_b_d  = sel_q;
                  mem_req_d = 1'b0;
                  state_d   = StIdle;
               end else begin
                  wd_cnt_d = wd_cnt_q + WdW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs: registered status plus port steering from the registered owner.
   always_comb begin
      done_a    = done_a_q;
      done_b    = done_b_q;
      err       = err_q;
      rdata     = rdata_q;
      sel       = sel_q;
      mem_req   = mem_req_q;
      mem_we    = sel_q & we_b;
      mem_addr  = sel_q ? addr_b : addr_a;
      mem_wdata = wdata_b;
   end

endmodule
